conv_pass_scheduler: RTL and testbench

- Top-level sequencer for one convolution layer of the VGG16 accelerator.
- Iterates over every (output filter, input channel) pair and runs one pass for each.
- Per pass: requests the weight load, streams a WIDTH x WIDTH feature-map plane as the valid_in source of the layer control chain (padding → 2D pipeline → bias), then waits for the chain's pass-complete pulse.
- Supplies the channel/filter indices and the first/last-channel flags that the accumulator and bias stage use.

---
 rtl/conv_pass_scheduler_if.sv | 32 +++
 rtl/conv_pass_scheduler.sv | 133 +++++++++++++
 tb/tb_conv_pass_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pass_scheduler_if.sv
// Handshake and index bundle between the layer sequencer and the weight
// loader, feature-map reader and layer control chain.
interface conv_pass_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 8
);
    logic              start;
    logic              weight_ready;
    logic              stall_in;
    logic              pass_done_in;
    logic              busy;
    logic              weight_load_req;
    logic              feed_valid;
    logic [ADDR_W-1:0] pixel_addr;
    logic [IDX_W-1:0]  channel_idx;
    logic [IDX_W-1:0]  filter_idx;
    logic              first_channel;
    logic              last_channel;
    logic              layer_done;

    modport master (
        input  start, weight_ready, stall_in, pass_done_in,
        output busy, weight_load_req, feed_valid, pixel_addr,
               channel_idx, filter_idx, first_channel, last_channel, layer_done
    );

    modport slave (
        output start, weight_ready, stall_in, pass_done_in,
        input  busy, weight_load_req, feed_valid, pixel_addr,
               channel_idx, filter_idx, first_channel, last_channel, layer_done
    );
endinterface

// File: rtl/conv_pass_scheduler.sv
// Layer sequencer: runs one weight-load / plane-stream / drain pass for every
// (output filter, input channel) pair of a convolution layer.
module conv_pass_scheduler #(
    parameter int WIDTH       = 5,
    parameter int NUM_CH      = 3,
    parameter int NUM_FILTERS = 64,
    parameter int ADDR_W      = 16,
    parameter int IDX_W       = 8
) (
    input logic                   clk,
    input logic                   rst,
    conv_pass_scheduler_if.master bus
);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(WIDTH * WIDTH - 1);
    localparam logic [IDX_W-1:0]  LAST_CH     = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0]  LAST_FILTER = IDX_W'(NUM_FILTERS - 1);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              weight_load_req_q, weight_load_req_d;
    logic              feed_valid_q, feed_valid_d;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic [IDX_W-1:0]  channel_idx_q, channel_idx_d;
    logic [IDX_W-1:0]  filter_idx_q, filter_idx_d;
    logic              first_channel_q, first_channel_d;
    logic              last_channel_q, last_channel_d;
    logic              layer_done_q, layer_done_d;

    // stall_in is registered through feed_valid_q: a stall sampled at an edge
    // suppresses the beat presented in the following cycle, and pixel_addr
    // then shows the next address still to be issued.
    always_comb begin
        state_d       = state_q;
        feed_valid_d  = 1'b0;
        pixel_addr_d  = pixel_addr_q;
        channel_idx_d = channel_idx_q;
        filter_idx_d  = filter_idx_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d       = LOAD;
                    channel_idx_d = '0;
                    filter_idx_d  = '0;
                end
            end
            LOAD: begin
                if (bus.weight_ready) begin
                    state_d      = STREAM;
                    pixel_addr_d = '0;
                    feed_valid_d = !bus.stall_in;
                end
            end
            STREAM: begin
                if (feed_valid_q && (pixel_addr_q == LAST_ADDR)) begin
                    state_d      = DRAIN;
                    pixel_addr_d = '0;
                end else begin
                    pixel_addr_d = feed_valid_q ? pixel_addr_q + ADDR_W'(1) : pixel_addr_q;
                    feed_valid_d = !bus.stall_in;
                end
            end
            DRAIN: begin
                if (bus.pass_done_in) begin
                    if (channel_idx_q == LAST_CH) begin
                        if (filter_idx_q == LAST_FILTER) begin
                            state_d = DONE;
                        end else begin
                            channel_idx_d = '0;
                            filter_idx_d  = filter_idx_q + IDX_W'(1);
                            state_d       = LOAD;
                        end
                    end else begin
                        channel_idx_d = channel_idx_q + IDX_W'(1);
                        state_d       = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d            = (state_d == LOAD) || (state_d == STREAM) || (state_d == DRAIN);
        weight_load_req_d = (state_d == LOAD);
        layer_done_d      = (state_d == DONE);
        first_channel_d   = busy_d && (channel_idx_d == '0);
        last_channel_d    = busy_d && (channel_idx_d == LAST_CH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            busy_q            <= 1'b0;
            weight_load_req_q <= 1'b0;
            feed_valid_q      <= 1'b0;
            pixel_addr_q      <= '0;
            channel_idx_q     <= '0;
            filter_idx_q      <= '0;
            first_channel_q   <= 1'b0;
            last_channel_q    <= 1'b0;
            layer_done_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            busy_q            <= busy_d;
            weight_load_req_q <= weight_load_req_d;
            feed_valid_q      <= feed_valid_d;
            pixel_addr_q      <= pixel_addr_d;
            channel_idx_q     <= channel_idx_d;
            filter_idx_q      <= filter_idx_d;
            first_channel_q   <= first_channel_d;
            last_channel_q    <= last_channel_d;
            layer_done_q      <= layer_done_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.weight_load_req = weight_load_req_q;
    assign bus.feed_valid      = feed_valid_q;
    assign bus.pixel_addr      = pixel_addr_q;
    assign bus.channel_idx     = channel_idx_q;
    assign bus.filter_idx      = filter_idx_q;
    assign bus.first_channel   = first_channel_q;
    assign bus.last_channel    = last_channel_q;
    assign bus.layer_done      = layer_done_q;

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Bench for conv_pass_scheduler: a 2x2 layer against a pass-level reference
// model, plus a directed single-pass run on a 1x1 layer instance.
module tb_conv_pass_scheduler;

    localparam int WIDTH  = 5;
    localparam int NC     = 2;
    localparam int NF     = 2;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 8;
    localparam int PIX    = WIDTH * WIDTH;

    typedef enum int {M_IDLE, M_LOAD, M_STREAM, M_DRAIN, M_DONE} phase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    phase_t phase       = M_IDLE;
    int     passNum     = 0;
    int     beatsIssued = 0;
    logic   expValid    = 1'b0;
    int     expAddr     = 0;

    int totalBeats  = 0;
    int doneCount   = 0;
    int layerBeats0 = 0;
    int layerDone0  = 0;
    int seen[$];

    conv_pass_scheduler_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus0 ();
    conv_pass_scheduler_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus1 ();

    conv_pass_scheduler #(
        .WIDTH(WIDTH), .NUM_CH(NC), .NUM_FILTERS(NF), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    conv_pass_scheduler #(
        .WIDTH(WIDTH), .NUM_CH(1), .NUM_FILTERS(1), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        phase       = M_IDLE;
        passNum     = 0;
        beatsIssued = 0;
        expValid    = 1'b0;
        expAddr     = 0;
    endtask

    // Pass-level model: passNum enumerates (filter, channel) pairs in order,
    // beatsIssued counts pixels handed to the chain in the current pass.
    task automatic modelStep(input logic st, input logic wr, input logic sl, input logic pd);
        expValid = 1'b0;
        case (phase)
            M_IDLE: if (st) begin
                phase   = M_LOAD;
                passNum = 0;
            end
            M_LOAD: if (wr) begin
                phase       = M_STREAM;
                beatsIssued = 0;
                if (!sl) begin
                    expValid    = 1'b1;
                    beatsIssued = 1;
                end
            end
            M_STREAM: begin
                if (beatsIssued == PIX) begin
                    phase = M_DRAIN;
                end else if (!sl) begin
                    expValid = 1'b1;
                    beatsIssued++;
                end
            end
            M_DRAIN: if (pd) begin
                if (passNum == NC * NF - 1) begin
                    phase = M_DONE;
                end else begin
                    passNum++;
                    phase = M_LOAD;
                end
            end
            default: phase = M_IDLE;
        endcase
        expAddr = (phase == M_STREAM) ? (expValid ? beatsIssued - 1 : beatsIssued) : 0;
    endtask

    task automatic compareAll();
        logic expBusy;
        int   ch;
        int   f;
        expBusy = (phase == M_LOAD) || (phase == M_STREAM) || (phase == M_DRAIN);
        ch = passNum % NC;
        f  = passNum / NC;
        checkOutput("busy", bus0.busy, expBusy);
        checkOutput("weight_load_req", bus0.weight_load_req, phase == M_LOAD);
        checkOutput("feed_valid", bus0.feed_valid, expValid);
        checkOutput("pixel_addr", bus0.pixel_addr, expAddr);
        checkOutput("channel_idx", bus0.channel_idx, ch);
        checkOutput("filter_idx", bus0.filter_idx, f);
        checkOutput("first_channel", bus0.first_channel, expBusy && (ch == 0));
        checkOutput("last_channel", bus0.last_channel, expBusy && (ch == NC - 1));
        checkOutput("layer_done", bus0.layer_done, phase == M_DONE);
    endtask

    task automatic applyStimulus(input logic st, input logic wr, input logic sl, input logic pd);
        bus0.start        = st;
        bus0.weight_ready = wr;
        bus0.stall_in     = sl;
        bus0.pass_done_in = pd;
        @(posedge clk);
        #1;
        modelStep(st, wr, sl, pd);
        if (bus0.feed_valid) begin
            totalBeats++;
            if (bus0.pixel_addr == 0)
                seen.push_back(int'(bus0.filter_idx) * 256 + int'(bus0.channel_idx));
        end
        if (bus0.layer_done) doneCount++;
        compareAll();
    endtask

    task automatic beginLayer();
        seen.delete();
        layerBeats0 = totalBeats;
        layerDone0  = doneCount;
    endtask

    task automatic endLayer();
        checkOutput("layerDoneCount", doneCount - layerDone0, 1);
        checkOutput("layerBeats", totalBeats - layerBeats0, NF * NC * PIX);
        checkOutput("passCount", seen.size(), NF * NC);
        for (int f = 0; f < NF; f++)
            for (int c = 0; c < NC; c++)
                if (f * NC + c < seen.size())
                    checkOutput("passOrder", seen[f * NC + c], f * 256 + c);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic finishLayer();
        int guard = 0;
        while (doneCount == layerDone0 && guard < 4000) begin
            applyStimulus(1'b0, 1'b1, 1'b0, phase == M_DRAIN);
            guard++;
        end
        endLayer();
    endtask

    task automatic runLayer(input bit randomMode);
        int guard = 0;
        beginLayer();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        while (doneCount == layerDone0 && guard < 4000) begin
            if (randomMode)
                applyStimulus($urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
                              (phase == M_DRAIN) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0));
            else
                applyStimulus(1'b0, 1'b1, 1'b0, phase == M_DRAIN);
            guard++;
        end
        endLayer();
    endtask

    task automatic stallAndSpuriousTest();
        int   pass0Beats;
        int   lastAddr = 0;
        int   stallLeft = 0;
        int   guard = 0;
        logic sl;
        logic spur;
        beginLayer();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("startToReq", bus0.weight_load_req, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("readyToValid", bus0.feed_valid, 1);
        pass0Beats = int'(bus0.feed_valid);
        while (phase == M_STREAM && guard < 200) begin
            sl   = (stallLeft > 0);
            spur = bus0.feed_valid && (bus0.pixel_addr == 15);
            applyStimulus(spur, 1'b0, sl, spur);
            if (sl) begin
                checkOutput("stallNoValid", bus0.feed_valid, 0);
                checkOutput("stallAddrHold", bus0.pixel_addr, 8);
                stallLeft--;
            end
            if (bus0.feed_valid) begin
                pass0Beats++;
                lastAddr = int'(bus0.pixel_addr);
                if (bus0.pixel_addr == 7) stallLeft = 4;
            end
            guard++;
        end
        checkOutput("pass0Beats", pass0Beats, PIX);
        checkOutput("pass0LastAddr", lastAddr, PIX - 1);
        checkOutput("spuriousNoIndex", bus0.channel_idx, 0);
        repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        finishLayer();
    endtask

    task automatic midResetTest();
        int guard = 0;
        beginLayer();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        while (!(passNum == NC && phase == M_STREAM && bus0.feed_valid && bus0.pixel_addr == 12)
               && guard < 1000) begin
            applyStimulus(1'b0, 1'b1, 1'b0, phase == M_DRAIN);
            guard++;
        end
        checkOutput("reachedAbortPoint", guard < 1000, 1);
        #2 rst = 1'b0;
        #1 modelReset();
        compareAll();
        repeat (2) begin
            @(posedge clk);
            #1 compareAll();
        end
        rst = 1'b1;
        checkOutput("abortNoDone", doneCount - layerDone0, 0);
        runLayer(1'b0);
    endtask

    task automatic singlePassTest();
        checkOutput("spIdleBusy", bus1.busy, 0);
        checkOutput("spIdleDone", bus1.layer_done, 0);
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        checkOutput("spReq", bus1.weight_load_req, 1);
        checkOutput("spBusy", bus1.busy, 1);
        @(posedge clk); #1;
        checkOutput("spReqHeld", bus1.weight_load_req, 1);
        bus1.weight_ready = 1'b1;
        @(posedge clk); #1;
        bus1.weight_ready = 1'b0;
        checkOutput("spReqDrop", bus1.weight_load_req, 0);
        for (int k = 0; k < PIX; k++) begin
            checkOutput("spValid", bus1.feed_valid, 1);
            checkOutput("spAddr", bus1.pixel_addr, k);
            checkOutput("spFirst", bus1.first_channel, 1);
            checkOutput("spLast", bus1.last_channel, 1);
            @(posedge clk); #1;
        end
        checkOutput("spDrainValid", bus1.feed_valid, 0);
        checkOutput("spDrainAddr", bus1.pixel_addr, 0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        checkOutput("spDrainBusy", bus1.busy, 1);
        checkOutput("spNoEarlyDone", bus1.layer_done, 0);
        bus1.pass_done_in = 1'b1;
        @(posedge clk); #1;
        bus1.pass_done_in = 1'b0;
        checkOutput("spDone", bus1.layer_done, 1);
        checkOutput("spDoneBusy", bus1.busy, 0);
        checkOutput("spDoneFirst", bus1.first_channel, 0);
        @(posedge clk); #1;
        checkOutput("spDonePulse", bus1.layer_done, 0);
    endtask

    initial begin
        bus0.start = 1'b0; bus0.weight_ready = 1'b0; bus0.stall_in = 1'b0; bus0.pass_done_in = 1'b0;
        bus1.start = 1'b0; bus1.weight_ready = 1'b0; bus1.stall_in = 1'b0; bus1.pass_done_in = 1'b0;
        #1 rst = 1'b0;
        modelReset();
        repeat (3) begin
            @(posedge clk);
            #1 compareAll();
        end
        rst = 1'b1;
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        stallAndSpuriousTest();
        midResetTest();
        repeat (3) runLayer(1'b1);
        singlePassTest();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
